// File: rtl/assign_clusters.sv
// assign_clusters: reads K squared distances per point from the DC BRAM,
// picks the argmin cluster per point, packs four 8-bit indices per word and
// writes the packed words into the cluster region of the IO BRAM.
// Optional feature macro: KMEANS_SUM_DIST_EN enables the 48-bit accumulator
// of per-point minimum distances on sum_dist_o (tied to 0 otherwise).
module assign_clusters #(
  parameter int DIST_W       = 32,
  parameter int DC_ADDR_W    = 16,
  parameter int IO_ADDR_W    = 16,
  parameter int MAX_CLUSTERS = 8,
  parameter logic [IO_ADDR_W-1:0] CLUSTER_BASE = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 ready_o,
  output logic                 done_o,
  input  logic [31:0]          num_points_i,
  input  logic [31:0]          num_clusters_i,
  output logic [DC_ADDR_W-1:0] dc_addr_o,
  input  logic [DIST_W-1:0]    dc_din_i,
  output logic [IO_ADDR_W-1:0] io_addr_o,
  output logic                 io_we_o,
  output logic [31:0]          io_dout_o,
  output logic [47:0]          sum_dist_o
);

  typedef enum logic [2:0] {IDLE, SCAN, LAST, WRITE, DONE} state_t;

  localparam logic [DC_ADDR_W-1:0] ADDR_ONE = 1;

  state_t state, next_state;

  logic [31:0]          pts;
  logic [31:0]          p;
  logic [7:0]           kmax;
  logic [7:0]           k;
  logic [7:0]           k_d;
  logic                 cmp_valid;
  logic [1:0]           lane;
  logic [31:0]          pack;
  logic [31:0]          pack_next;
  logic [DIST_W-1:0]    best_dist;
  logic [7:0]           best_idx;
  logic [DC_ADDR_W-1:0] next_addr;
  logic [DC_ADDR_W-1:0] addr_q;
  logic [IO_ADDR_W-1:0] io_addr_q;
  logic [31:0]          io_dout_q;

  logic [7:0]           k_clamped;
  logic                 empty_run;
  logic                 last_k;
  logic                 last_point;
  logic                 take_new;
  logic [7:0]           cand_idx;
  logic                 word_full;

  // K is saturated to MAX_CLUSTERS; the address walk is contiguous
  // (point-major layout), so a running counter replaces p*K+k.
  assign k_clamped  = (num_clusters_i > 32'(MAX_CLUSTERS)) ? 8'(MAX_CLUSTERS)
                                                           : num_clusters_i[7:0];
  assign empty_run  = (num_points_i == 32'd0) || (num_clusters_i == 32'd0);
  assign last_k     = (k == kmax - 8'd1);
  assign last_point = (p == pts - 32'd1);
  assign word_full  = (lane == 2'd3);

  // Distance returned this cycle replaces the running best on the first
  // cluster of a point or on a strictly smaller value (ties keep lower index).
  assign take_new = (k_d == 8'd0) || (dc_din_i < best_dist);
  assign cand_idx = take_new ? k_d : best_idx;

  assign ready_o   = (state == IDLE);
  assign done_o    = (state == DONE);
  assign io_we_o   = (state == WRITE);
  assign io_addr_o = io_addr_q;
  assign io_dout_o = io_dout_q;
  assign dc_addr_o = (state == SCAN) ? next_addr : addr_q;

  // Current word with the final winner of this point inserted into its lane.
  always_comb begin
    pack_next = pack;
    pack_next[8*lane +: 8] = cand_idx;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_i) next_state = empty_run ? DONE : SCAN;
      SCAN:    if (last_k) next_state = LAST;
      LAST:    next_state = (word_full || last_point) ? WRITE : SCAN;
      WRITE:   next_state = last_point ? DONE : SCAN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counters, compare pipeline, packing and IO word registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pts       <= '0;
      p         <= '0;
      kmax      <= '0;
      k         <= '0;
      k_d       <= '0;
      cmp_valid <= 1'b0;
      lane      <= '0;
      pack      <= '0;
      best_dist <= '0;
      best_idx  <= '0;
      next_addr <= '0;
      addr_q    <= '0;
      io_addr_q <= '0;
      io_dout_q <= '0;
    end else begin
      cmp_valid <= (state == SCAN);
      k_d       <= k;
      if (cmp_valid && take_new) begin
        best_dist <= dc_din_i;
        best_idx  <= k_d;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            pts       <= num_points_i;
            kmax      <= k_clamped;
            p         <= '0;
            k         <= '0;
            lane      <= '0;
            pack      <= '0;
            next_addr <= '0;
          end
        end
        SCAN: begin
          addr_q    <= next_addr;
          next_addr <= next_addr + ADDR_ONE;
          k         <= k + 8'd1;
        end
        LAST: begin
          pack <= pack_next;
          k    <= '0;
          if (word_full || last_point) begin
            io_addr_q <= CLUSTER_BASE + p[IO_ADDR_W+1:2];
            io_dout_q <= pack_next;
          end else begin
            lane <= lane + 2'd1;
            p    <= p + 32'd1;
          end
        end
        WRITE: begin
          pack <= '0;
          lane <= '0;
          k    <= '0;
          if (!last_point) p <= p + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef KMEANS_SUM_DIST_EN
  logic [47:0]       sum_q;
  logic [DIST_W-1:0] cand_dist;

  assign cand_dist  = take_new ? dc_din_i : best_dist;
  assign sum_dist_o = sum_q;

  // Accumulate each point's minimum distance; cleared when a run starts.
  always_ff @(posedge clk_i) begin
    if (reset_i)                        sum_q <= '0;
    else if (state == IDLE && start_i)  sum_q <= '0;
    else if (state == LAST)             sum_q <= sum_q + 48'(cand_dist);
  end
`else
  assign sum_dist_o = '0;
`endif

endmodule

// File: tb/tb_assign_clusters.sv
// Testbench for assign_clusters: a BRAM model feeds distances, writes are
// captured into queues and compared against an argmin/packing reference.
module tb_assign_clusters;

  localparam int          MAXK  = 8;
  localparam logic [15:0] BASE  = 16'h0000;
  localparam int          LIMIT = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ready, done, io_we;
  logic [31:0] num_points = '0, num_clusters = '0;
  logic [15:0] dc_addr, io_addr;
  logic [31:0] dc_din = '0, io_dout;
  logic [47:0] sum_dist;

  logic [31:0] mem [0:65535];
  int case1_d [12] = '{5, 2, 9, 1, 1, 4, 7, 8, 0, 3, 6, 3};

  int checks = 0;
  int failures = 0;

  logic [15:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [15:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [47:0] exp_sum;
  int          exp_lat;

  assign_clusters #(
    .DIST_W(32), .DC_ADDR_W(16), .IO_ADDR_W(16),
    .MAX_CLUSTERS(MAXK), .CLUSTER_BASE(BASE)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .ready_o(ready),
    .done_o(done), .num_points_i(num_points), .num_clusters_i(num_clusters),
    .dc_addr_o(dc_addr), .dc_din_i(dc_din), .io_addr_o(io_addr),
    .io_we_o(io_we), .io_dout_o(io_dout), .sum_dist_o(sum_dist)
  );

  always #5 clk = ~clk;

  // Synchronous-read DC BRAM: data for an address appears the next cycle.
  always @(posedge clk) dc_din <= mem[dc_addr];

  // Capture every IO write.
  always @(negedge clk) begin
    if (io_we) begin
      wr_addr_q.push_back(io_addr);
      wr_data_q.push_back(io_dout);
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] expected);
    checks++;
    assert (obs === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expected);
    end
  endtask

  task automatic fill_random(input int n, input int maxval);
    for (int a = 0; a < n; a++)
      mem[a] = (maxval == 0) ? $urandom : $urandom_range(maxval, 0);
  endtask

  // Reference: argmin per point over the first min(K,MAX) distances,
  // four indices per word, partial last word zero-padded.
  task automatic build_model(input int np, input int nk);
    int keff;
    int idx [$];
    logic [31:0] best, d, word;
    int bi;
    keff = (nk > MAXK) ? MAXK : nk;
    exp_addr.delete();
    exp_data.delete();
    exp_sum = '0;
    if (np == 0 || keff == 0) begin
      exp_lat = 1;
      return;
    end
    for (int p = 0; p < np; p++) begin
      best = mem[16'(p * keff)];
      bi = 0;
      for (int k = 1; k < keff; k++) begin
        d = mem[16'(p * keff + k)];
        if (d < best) begin
          best = d;
          bi = k;
        end
      end
      idx.push_back(bi);
      exp_sum = exp_sum + 48'(best);
    end
    for (int w = 0; w < (np + 3) / 4; w++) begin
      word = '0;
      for (int l = 0; l < 4; l++)
        if (w * 4 + l < np) word = word | (32'(idx[w * 4 + l]) << (8 * l));
      exp_addr.push_back(BASE + 16'(w));
      exp_data.push_back(word);
    end
    exp_lat = np * (keff + 1) + (np + 3) / 4 + 1;
  endtask

  // Run one job, optionally pulsing start mid-run, and check everything.
  task automatic apply_stimulus(input string tag, input int np, input int nk,
                                input bit mid_start);
    int lat;
    logic [47:0] sum_exp;
    build_model(np, nk);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    num_points = 32'(np);
    num_clusters = 32'(nk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= LIMIT; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (n == 1) check_output({tag, ".busy"}, 64'(ready), 64'd0);
      if (mid_start && n == 4) start = 1'b1;
      if (mid_start && n == 5) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check_output({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_output({tag, ".nwrites"}, 64'(wr_addr_q.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
      check_output($sformatf("%s.addr%0d", tag, i), 64'(wr_addr_q[i]), 64'(exp_addr[i]));
      check_output($sformatf("%s.data%0d", tag, i), 64'(wr_data_q[i]), 64'(exp_data[i]));
    end
`ifdef KMEANS_SUM_DIST_EN
    sum_exp = exp_sum;
`else
    sum_exp = '0;
`endif
    check_output({tag, ".sum"}, 64'(sum_dist), 64'(sum_exp));
    @(posedge clk);
    #1;
    check_output({tag, ".ready_after"}, 64'(ready), 64'd1);
    check_output({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int np, nk;
    for (int a = 0; a < 65536; a++) mem[a] = 32'hFFFF_FFFF;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst.ready", 64'(ready), 64'd1);
    check_output("rst.done", 64'(done), 64'd0);
    check_output("rst.io_we", 64'(io_we), 64'd0);
    check_output("rst.dc_addr", 64'(dc_addr), 64'd0);
    check_output("rst.io_addr", 64'(io_addr), 64'd0);
    check_output("rst.io_dout", 64'(io_dout), 64'd0);
    check_output("rst.sum", 64'(sum_dist), 64'd0);
    reset = 1'b0;

    // Fixed 4x3 example, including a tie.
    for (int a = 0; a < 12; a++) mem[a] = 32'(case1_d[a]);
    apply_stimulus("case1", 4, 3, 1'b0);

    // Five points, minimum always at index 1: full word then partial word.
    for (int p = 0; p < 5; p++) begin
      mem[2 * p]     = 32'(100 + p);
      mem[2 * p + 1] = 32'(p);
    end
    apply_stimulus("case2", 5, 2, 1'b0);

    // Empty jobs.
    apply_stimulus("p0", 0, 3, 1'b0);
    apply_stimulus("k0", 3, 0, 1'b0);

    // Reset during the second point's scan, then a clean restart.
    fill_random(16, 15);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    num_points = 32'd8;
    num_clusters = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst.ready", 64'(ready), 64'd1);
    check_output("midrst.io_we", 64'(io_we), 64'd0);
    check_output("midrst.done", 64'(done), 64'd0);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_output("midrst.nwrites", 64'(wr_addr_q.size()), 64'd0);
    apply_stimulus("restart", 8, 2, 1'b0);

    // K above the maximum is clamped; a start pulse mid-run is ignored.
    fill_random(96, 7);
    apply_stimulus("clampK", 6, 12, 1'b1);

    // Edge shapes: single cluster, single point.
    fill_random(4, 0);
    apply_stimulus("k1", 4, 1, 1'b0);
    fill_random(8, 3);
    apply_stimulus("p1", 1, 8, 1'b0);

    // Randomized jobs, alternating small ranges (many ties) and full range.
    for (int t = 0; t < 6; t++) begin
      np = $urandom_range(13, 1);
      nk = $urandom_range(11, 1);
      fill_random(np * 11, (t % 2 == 0) ? 3 : 0);
      apply_stimulus($sformatf("rand%0d", t), np, nk, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
